scan_controller: RTL and testbench

SCAN_CONTROLLER -- requirements
Module: scan_controller

---
 rtl/scan_controller_pkg.sv | 37 +++
 rtl/scan_controller_scan_counter.sv | 49 ++++
 rtl/scan_controller.sv | 178 +++++++++++++++++
 tb/tb_scan_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_controller_pkg.sv
// Shared types and widths for the raster scan controller: FSM states,
// default geometry, configuration field widths and the thickness clamp.
package scan_controller_pkg;

    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;

    localparam int RADIUS_W = 10;
    localparam int THICK_W  = 6;
    localparam int XC_W     = 10;
    localparam int YC_W     = 9;
    localparam int PIX_X_W  = 10;
    localparam int PIX_Y_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2
    } scan_state_t;

    // A ring can never be thicker than its radius; cap it, saturating to the field max.
    function automatic logic [THICK_W-1:0] clamp_thickness(
        input logic [RADIUS_W-1:0] radius,
        input logic [THICK_W-1:0]  thick
    );
        logic [THICK_W-1:0] result;
        result = thick;
        if ({{(RADIUS_W-THICK_W){1'b0}}, thick} > radius) begin
            if (|radius[RADIUS_W-1:THICK_W])
                result = '1;
            else
                result = radius[THICK_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_controller_scan_counter.sv
// Raster x/y position counter: advances on enable, wraps at line and frame
// ends, and flags the last pixel of a line and of a frame.
module scan_counter
    import scan_controller_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               i_clear,
    input  logic               i_adv,
    output logic [PIX_X_W-1:0] o_x,
    output logic [PIX_Y_W-1:0] o_y,
    output logic               o_x_last,
    output logic               o_frame_last
);

    logic [PIX_X_W-1:0] r_x;
    logic [PIX_Y_W-1:0] r_y;
    logic               w_x_last;
    logic               w_y_last;

    assign w_x_last = (r_x == PIX_X_W'(X_SIZE - 1));
    assign w_y_last = (r_y == PIX_Y_W'(Y_SIZE - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + PIX_Y_W'(1);
            end else begin
                r_x <= r_x + PIX_X_W'(1);
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_x_last     = w_x_last;
    assign o_frame_last = w_x_last & w_y_last;

endmodule

// File: rtl/scan_controller.sv
// Raster scan sequencer: emits frame coordinates over a valid/ready handshake
// and latches shadowed shape configuration once per frame.
//
//   state | meaning
//   IDLE  | waiting for start, no pixels presented
//   LOAD  | one cycle: shadow -> act_*, counter cleared
//   SCAN  | presenting coordinates, advancing on handshake
module scan_controller
    import scan_controller_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF,
    parameter int FCNT_W = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic                cfg_wr,
    input  logic [RADIUS_W-1:0] cfg_radius,
    input  logic [THICK_W-1:0]  cfg_thickness,
    input  logic [XC_W-1:0]     cfg_x_center,
    input  logic [YC_W-1:0]     cfg_y_center,
    output logic [RADIUS_W-1:0] act_radius,
    output logic [THICK_W-1:0]  act_thickness,
    output logic [XC_W-1:0]     act_x_center,
    output logic [YC_W-1:0]     act_y_center,
    output logic [PIX_X_W-1:0]  pix_x,
    output logic [PIX_Y_W-1:0]  pix_y,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                pix_sof,
    output logic                pix_eol,
    output logic                busy,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_count
);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic                r_stop_pending;
    logic                w_stop_pending_nxt;
    logic                r_frame_done;
    logic [FCNT_W-1:0]   r_frame_count;

    logic [RADIUS_W-1:0] r_sh_radius;
    logic [THICK_W-1:0]  r_sh_thickness;
    logic [XC_W-1:0]     r_sh_x_center;
    logic [YC_W-1:0]     r_sh_y_center;
    logic [RADIUS_W-1:0] r_act_radius;
    logic [THICK_W-1:0]  r_act_thickness;
    logic [XC_W-1:0]     r_act_x_center;
    logic [YC_W-1:0]     r_act_y_center;

    logic                w_valid;
    logic                w_accept;
    logic                w_last_accept;
    logic                w_load;
    logic                w_x_last;
    logic                w_frame_last;
    logic [PIX_X_W-1:0]  w_x;
    logic [PIX_Y_W-1:0]  w_y;

    assign w_valid       = (r_state == ST_SCAN);
    assign w_load        = (r_state == ST_LOAD);
    assign w_accept      = w_valid & pix_ready;
    assign w_last_accept = w_accept & w_frame_last;

    scan_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_scan_counter (
        .aclk         (aclk),
        .areset       (areset),
        .i_clear      (w_load),
        .i_adv        (w_accept),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_x_last     (w_x_last),
        .o_frame_last (w_frame_last)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_stop_pending_nxt = r_stop_pending;
        case (r_state)
            ST_IDLE: begin
                // A stop arriving with start still lets exactly one frame run.
                if (start) begin
                    w_state_nxt        = ST_LOAD;
                    w_stop_pending_nxt = stop;
                end else begin
                    w_stop_pending_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SCAN;
                if (stop)
                    w_stop_pending_nxt = 1'b1;
            end
            ST_SCAN: begin
                if (stop)
                    w_stop_pending_nxt = 1'b1;
                if (w_last_accept) begin
                    if (continuous && !(r_stop_pending || stop)) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt        = ST_IDLE;
                        w_stop_pending_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt        = ST_IDLE;
                w_stop_pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state        <= ST_IDLE;
            r_stop_pending <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_stop_pending <= w_stop_pending_nxt;
            r_frame_done   <= w_last_accept;
            if (w_last_accept)
                r_frame_count <= r_frame_count + FCNT_W'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sh_radius    <= '0;
            r_sh_thickness <= '0;
            r_sh_x_center  <= '0;
            r_sh_y_center  <= '0;
        end else if (cfg_wr) begin
            r_sh_radius    <= cfg_radius;
            r_sh_thickness <= clamp_thickness(cfg_radius, cfg_thickness);
            r_sh_x_center  <= cfg_x_center;
            r_sh_y_center  <= cfg_y_center;
        end
    end

    // A write landing in the LOAD cycle itself is picked up one frame later.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_act_radius    <= '0;
            r_act_thickness <= '0;
            r_act_x_center  <= '0;
            r_act_y_center  <= '0;
        end else if (w_load) begin
            r_act_radius    <= r_sh_radius;
            r_act_thickness <= r_sh_thickness;
            r_act_x_center  <= r_sh_x_center;
            r_act_y_center  <= r_sh_y_center;
        end
    end

    assign act_radius    = r_act_radius;
    assign act_thickness = r_act_thickness;
    assign act_x_center  = r_act_x_center;
    assign act_y_center  = r_act_y_center;
    assign pix_x         = w_x;
    assign pix_y         = w_y;
    assign pix_valid     = w_valid;
    assign pix_sof       = w_valid & (w_x == '0) & (w_y == '0);
    assign pix_eol       = w_valid & w_x_last;
    assign busy          = (r_state != ST_IDLE);
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_scan_controller.sv
// Scoreboard bench for scan_controller on a reduced 8x4 raster: stimulus
// queues expected pixels, a negedge monitor pops and compares each handshake.
module tb_scan_controller;

    localparam int XS   = 8;
    localparam int YS   = 4;
    localparam int NPIX = XS * YS;
    localparam int FW   = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [9:0]  cfg_radius = '0;
    logic [5:0]  cfg_thickness = '0;
    logic [9:0]  cfg_x_center = '0;
    logic [8:0]  cfg_y_center = '0;
    logic        pix_ready = 1'b1;

    logic [9:0]  act_radius;
    logic [5:0]  act_thickness;
    logic [9:0]  act_x_center;
    logic [8:0]  act_y_center;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_eol;
    logic        busy;
    logic        frame_done;
    logic [FW-1:0] frame_count;

    scan_controller #(
        .X_SIZE (XS),
        .Y_SIZE (YS),
        .FCNT_W (FW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .stop          (stop),
        .continuous    (continuous),
        .cfg_wr        (cfg_wr),
        .cfg_radius    (cfg_radius),
        .cfg_thickness (cfg_thickness),
        .cfg_x_center  (cfg_x_center),
        .cfg_y_center  (cfg_y_center),
        .act_radius    (act_radius),
        .act_thickness (act_thickness),
        .act_x_center  (act_x_center),
        .act_y_center  (act_y_center),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       sof;
        logic       eol;
        logic [9:0] rad;
        logic [5:0] thk;
        logic [9:0] xc;
        logic [8:0] yc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_accept = 0;
    int   n_done   = 0;
    int   n_eol    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [9:0] rad, input logic [5:0] thk,
                              input logic [9:0] xc, input logic [8:0] yc);
        exp_t e;
        for (int y = 0; y < YS; y++) begin
            for (int x = 0; x < XS; x++) begin
                e.x   = 10'(x);
                e.y   = 9'(y);
                e.sof = (x == 0) && (y == 0);
                e.eol = (x == XS - 1);
                e.rad = rad;
                e.thk = thk;
                e.xc  = xc;
                e.yc  = yc;
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: compare each accepted pixel, and verify outputs held across stalls.
    logic       prev_stall = 1'b0;
    logic [9:0] p_x;
    logic [8:0] p_y;
    logic       p_sof;
    logic       p_eol;
    logic [9:0] p_rad;

    always @(negedge aclk) begin
        exp_t e;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(pix_valid), 32'(1));
                check("stall_x", 32'(pix_x), 32'(p_x));
                check("stall_y", 32'(pix_y), 32'(p_y));
                check("stall_sof", 32'(pix_sof), 32'(p_sof));
                check("stall_eol", 32'(pix_eol), 32'(p_eol));
                check("stall_radius", 32'(act_radius), 32'(p_rad));
            end
            if (pix_valid && pix_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_underflow: got pixel (%0d,%0d) expected none", pix_x, pix_y);
                end else begin
                    e = sb.pop_front();
                    check("pix_x", 32'(pix_x), 32'(e.x));
                    check("pix_y", 32'(pix_y), 32'(e.y));
                    check("pix_sof", 32'(pix_sof), 32'(e.sof));
                    check("pix_eol", 32'(pix_eol), 32'(e.eol));
                    check("act_radius", 32'(act_radius), 32'(e.rad));
                    check("act_thickness", 32'(act_thickness), 32'(e.thk));
                    check("act_x_center", 32'(act_x_center), 32'(e.xc));
                    check("act_y_center", 32'(act_y_center), 32'(e.yc));
                end
                n_accept++;
                if (pix_eol) n_eol++;
            end
            if (frame_done) n_done++;
            prev_stall = pix_valid && !pix_ready;
            p_x   = pix_x;
            p_y   = pix_y;
            p_sof = pix_sof;
            p_eol = pix_eol;
            p_rad = act_radius;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic write_cfg(input logic [9:0] rad, input logic [5:0] thk,
                             input logic [9:0] xc, input logic [8:0] yc);
        cfg_radius    = rad;
        cfg_thickness = thk;
        cfg_x_center  = xc;
        cfg_y_center  = yc;
        cfg_wr        = 1'b1;
        cyc(1);
        cfg_wr        = 1'b0;
    endtask

    task automatic start_frame(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check("load_busy", 32'(busy), 32'(1));
        check("load_valid", 32'(pix_valid), 32'(0));
        cyc(1);
        check("c2_valid", 32'(pix_valid), 32'(1));
        check("c2_sof", 32'(pix_sof), 32'(1));
        check("c2_x", 32'(pix_x), 32'(0));
        check("c2_y", 32'(pix_y), 32'(0));
    endtask

    task automatic wait_idle(input logic rnd, input string name);
        int k = 0;
        while (busy && k < 5000) begin
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            cyc(1);
            k++;
        end
        pix_ready = 1'b1;
        check(name, 32'(busy), 32'(0));
        cyc(2);
    endtask

    task automatic wait_load(input string name);
        int k = 0;
        while (!(busy && !pix_valid) && k < 1000) begin
            cyc(1);
            k++;
        end
        check(name, 32'(busy && !pix_valid), 32'(1));
    endtask

    task automatic wait_accept(input int target, input string name);
        int k = 0;
        while (n_accept < target && k < 1000) begin
            cyc(1);
            k++;
        end
        check(name, 32'(n_accept >= target), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(frame_done), 32'(0));
        check({tag, "_fcnt"}, 32'(frame_count), 32'(0));
        check({tag, "_x"}, 32'(pix_x), 32'(0));
        check({tag, "_y"}, 32'(pix_y), 32'(0));
        check({tag, "_sof"}, 32'(pix_sof), 32'(0));
        check({tag, "_eol"}, 32'(pix_eol), 32'(0));
        check({tag, "_radius"}, 32'(act_radius), 32'(0));
        check({tag, "_thick"}, 32'(act_thickness), 32'(0));
        check({tag, "_xc"}, 32'(act_x_center), 32'(0));
        check({tag, "_yc"}, 32'(act_y_center), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_acc;
        int base_done;
        int base_eol;
        int k;

        #1 areset = 1'b1;
        #1 check_all_zero("rst");
        cyc(2);
        areset = 1'b0;
        cyc(1);

        // single frame, ready held high
        write_cfg(10'd20, 6'd5, 10'd7, 9'd3);
        base_acc  = n_accept;
        base_done = n_done;
        push_frame(10'd20, 6'd5, 10'd7, 9'd3);
        start_frame(1'b0);
        wait_idle(1'b0, "t1_idle");
        check("t1_accepted", 32'(n_accept - base_acc), 32'(NPIX));
        check("t1_done", 32'(n_done - base_done), 32'(1));
        check("t1_fcnt", 32'(frame_count), 32'(1));
        check("t1_sb_empty", 32'(sb.size()), 32'(0));

        // single frame with random ready stalls
        base_acc  = n_accept;
        base_done = n_done;
        base_eol  = n_eol;
        push_frame(10'd20, 6'd5, 10'd7, 9'd3);
        start_frame(1'b0);
        wait_idle(1'b1, "t2_idle");
        check("t2_accepted", 32'(n_accept - base_acc), 32'(NPIX));
        check("t2_eol", 32'(n_eol - base_eol), 32'(YS));
        check("t2_done", 32'(n_done - base_done), 32'(1));
        check("t2_fcnt", 32'(frame_count), 32'(2));
        check("t2_sb_empty", 32'(sb.size()), 32'(0));

        // continuous, stop in the middle of frame 2
        continuous = 1'b1;
        base_acc   = n_accept;
        base_done  = n_done;
        push_frame(10'd20, 6'd5, 10'd7, 9'd3);
        push_frame(10'd20, 6'd5, 10'd7, 9'd3);
        start_frame(1'b0);
        wait_accept(base_acc + NPIX + 10, "t3_mid2");
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_idle(1'b0, "t3_idle");
        check("t3_accepted", 32'(n_accept - base_acc), 32'(2 * NPIX));
        check("t3_done", 32'(n_done - base_done), 32'(2));
        check("t3_fcnt", 32'(frame_count), 32'(4));
        check("t3_sb_empty", 32'(sb.size()), 32'(0));
        cyc(5);
        check("t3_stays_idle", 32'(busy), 32'(0));

        // shadow config: mid-frame write applies next frame, LOAD-cycle write one frame later
        base_done = n_done;
        push_frame(10'd20, 6'd5, 10'd7, 9'd3);
        push_frame(10'd100, 6'd5, 10'd7, 9'd3);
        push_frame(10'd100, 6'd5, 10'd7, 9'd3);
        push_frame(10'd50, 6'd5, 10'd7, 9'd3);
        start_frame(1'b0);
        cyc(5);
        write_cfg(10'd100, 6'd5, 10'd7, 9'd3);
        check("t4_radius_held", 32'(act_radius), 32'(20));
        wait_load("t4_load_b");
        cyc(1);
        wait_load("t4_load_c");
        write_cfg(10'd50, 6'd5, 10'd7, 9'd3);
        check("t4_radius_deferred", 32'(act_radius), 32'(100));
        wait_load("t4_load_d");
        cyc(1);
        check("t4_radius_new", 32'(act_radius), 32'(50));
        cyc(3);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_idle(1'b0, "t4_idle");
        check("t4_done", 32'(n_done - base_done), 32'(4));
        check("t4_fcnt", 32'(frame_count), 32'(8));
        check("t4_sb_empty", 32'(sb.size()), 32'(0));

        // thickness clamp
        continuous = 1'b0;
        write_cfg(10'd3, 6'd10, 10'd7, 9'd3);
        push_frame(10'd3, 6'd3, 10'd7, 9'd3);
        start_frame(1'b0);
        check("t5_thick_clamped", 32'(act_thickness), 32'(3));
        wait_idle(1'b0, "t5_idle");
        check("t5_fcnt", 32'(frame_count), 32'(9));

        // start and stop together in IDLE with continuous set: one frame only
        continuous = 1'b1;
        base_done  = n_done;
        push_frame(10'd3, 6'd3, 10'd7, 9'd3);
        start_frame(1'b1);
        wait_idle(1'b0, "t7_idle");
        check("t7_done", 32'(n_done - base_done), 32'(1));
        check("t7_fcnt", 32'(frame_count), 32'(10));
        check("t7_sb_empty", 32'(sb.size()), 32'(0));

        // async reset mid-frame
        continuous = 1'b0;
        push_frame(10'd3, 6'd3, 10'd7, 9'd3);
        start_frame(1'b0);
        k = 0;
        while (!(pix_x == 10'd5 && pix_y == 9'd2) && k < 200) begin
            cyc(1);
            k++;
        end
        check("t6_reached", 32'(pix_x == 10'd5 && pix_y == 9'd2), 32'(1));
        base_done = n_done;
        areset = 1'b1;
        #1;
        check_all_zero("t6_rst");
        sb.delete();
        cyc(2);
        areset = 1'b0;
        cyc(3);
        check("t6_idle_after", 32'(busy), 32'(0));
        check("t6_no_done", 32'(n_done - base_done), 32'(0));
        push_frame(10'd0, 6'd0, 10'd0, 9'd0);
        start_frame(1'b0);
        wait_idle(1'b0, "t6_idle");
        check("t6_fcnt", 32'(frame_count), 32'(1));
        check("t6_sb_empty", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
